// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared pipeline-stage types and the ID/EX payload field layout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } pipe_state_t;

    // ID/EX bundle: instantiation sites pack/unpack payloads with these.
    localparam int c_IDEX_INST_W       = 32;
    localparam int c_IDEX_INST_ADDR_W  = 32;
    localparam int c_IDEX_REG_DATA_W   = 32;
    localparam int c_IDEX_REG_W_E_W    = 1;
    localparam int c_IDEX_REG_W_ADDR_W = 5;
    localparam int c_IDEX_OP_W         = 32;

    localparam int c_IDEX_INST_OFF       = 0;
    localparam int c_IDEX_INST_ADDR_OFF  = c_IDEX_INST_OFF + c_IDEX_INST_W;
    localparam int c_IDEX_REG1_OFF       = c_IDEX_INST_ADDR_OFF + c_IDEX_INST_ADDR_W;
    localparam int c_IDEX_REG2_OFF       = c_IDEX_REG1_OFF + c_IDEX_REG_DATA_W;
    localparam int c_IDEX_REG_W_E_OFF    = c_IDEX_REG2_OFF + c_IDEX_REG_DATA_W;
    localparam int c_IDEX_REG_W_ADDR_OFF = c_IDEX_REG_W_E_OFF + c_IDEX_REG_W_E_W;
    localparam int c_IDEX_OP1_OFF        = c_IDEX_REG_W_ADDR_OFF + c_IDEX_REG_W_ADDR_W;
    localparam int c_IDEX_OP2_OFF        = c_IDEX_OP1_OFF + c_IDEX_OP_W;
    localparam int c_IDEX_OP1_JUMP_OFF   = c_IDEX_OP2_OFF + c_IDEX_OP_W;
    localparam int c_IDEX_OP2_JUMP_OFF   = c_IDEX_OP1_JUMP_OFF + c_IDEX_OP_W;
    localparam int c_IDEX_USED_W         = c_IDEX_OP2_JUMP_OFF + c_IDEX_OP_W;
    localparam int c_IDEX_W              = 294;

endpackage

`default_nettype wire

// File: rtl/pipe_sat_counter.sv
// ============================================================================
// Module   : pipe_sat_counter
// Brief    : Up-counter that sticks at all ones; cleared only by reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_100MHz,
    input  logic         arst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_skid_stage.sv
// ============================================================================
// Module   : pipe_skid_stage
// Brief    : Valid/ready pipeline register with one-entry skid, hold and flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 294,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W      = 16
) (
    input  logic              clk_100MHz,
    input  logic              arst_n,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              down_valid_o,
    input  logic              down_ready_i,
    output logic [DATA_W-1:0] down_data_o,
    input  logic              hold_ena_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  bp_cnt_o
);

    pipe_state_t       r_state;
    logic [DATA_W-1:0] r_out;
    logic [DATA_W-1:0] r_skid;

    logic w_up_ready;
    logic w_down_valid;
    logic w_up_fire;
    logic w_down_fire;
    logic w_bp_inc;

    // Handshakes depend only on state and hold, so ready never combinationally follows downstream.
    assign w_up_ready   = (r_state != FULL)  & ~hold_ena_i;
    assign w_down_valid = (r_state != EMPTY) & ~hold_ena_i;
    assign w_up_fire    = up_valid_i & w_up_ready;
    assign w_down_fire  = w_down_valid & down_ready_i;
    assign w_bp_inc     = w_down_valid & ~down_ready_i & ~flush_i;

    always_ff @(posedge clk_100MHz or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= EMPTY;
            r_out   <= BUBBLE_VAL;
            r_skid  <= BUBBLE_VAL;
        end else if (hold_ena_i) begin
            r_state <= r_state;
        end else if (flush_i) begin
            r_state <= EMPTY;
            r_out   <= BUBBLE_VAL;
            r_skid  <= BUBBLE_VAL;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_up_fire) begin
                        r_out   <= up_data_i;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_up_fire && w_down_fire) begin
                        r_out <= up_data_i;
                    end else if (w_up_fire) begin
                        r_skid  <= up_data_i;
                        r_state <= FULL;
                    end else if (w_down_fire) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_down_fire) begin
                        r_out   <= r_skid;
                        r_state <= BUSY;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                end
            endcase
        end
    end

    pipe_sat_counter #(
        .W (CNT_W)
    ) u_bp_cnt (
        .clk_100MHz (clk_100MHz),
        .arst_n     (arst_n),
        .inc        (w_bp_inc),
        .count      (bp_cnt_o)
    );

    assign up_ready_o   = w_up_ready;
    assign down_valid_o = w_down_valid;
    assign down_data_o  = r_out;

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// ============================================================================
// Module   : tb_pipe_skid_stage
// Brief    : Directed self-checking bench for pipe_skid_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_skid_stage;

    localparam int c_DW  = 294;
    localparam int c_CW  = 16;
    localparam int c_SDW = 8;
    localparam int c_SCW = 4;

    logic              clk_100MHz = 1'b0;
    logic              arst_n     = 1'b0;
    logic              up_valid   = 1'b0;
    logic              up_ready;
    logic [c_DW-1:0]   up_data    = '0;
    logic              down_valid;
    logic              down_ready = 1'b0;
    logic [c_DW-1:0]   down_data;
    logic              hold_ena   = 1'b0;
    logic              flush      = 1'b0;
    logic [c_CW-1:0]   bp_cnt;

    logic              s_up_valid   = 1'b0;
    logic              s_up_ready;
    logic [c_SDW-1:0]  s_up_data    = '0;
    logic              s_down_valid;
    logic              s_down_ready = 1'b0;
    logic [c_SDW-1:0]  s_down_data;
    logic [c_SCW-1:0]  s_bp_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    pipe_skid_stage #(
        .DATA_W (c_DW),
        .CNT_W  (c_CW)
    ) dut (
        .clk_100MHz   (clk_100MHz),
        .arst_n       (arst_n),
        .up_valid_i   (up_valid),
        .up_ready_o   (up_ready),
        .up_data_i    (up_data),
        .down_valid_o (down_valid),
        .down_ready_i (down_ready),
        .down_data_o  (down_data),
        .hold_ena_i   (hold_ena),
        .flush_i      (flush),
        .bp_cnt_o     (bp_cnt)
    );

    pipe_skid_stage #(
        .DATA_W (c_SDW),
        .CNT_W  (c_SCW)
    ) dut_sat (
        .clk_100MHz   (clk_100MHz),
        .arst_n       (arst_n),
        .up_valid_i   (s_up_valid),
        .up_ready_o   (s_up_ready),
        .up_data_i    (s_up_data),
        .down_valid_o (s_down_valid),
        .down_ready_i (s_down_ready),
        .down_data_o  (s_down_data),
        .hold_ena_i   (1'b0),
        .flush_i      (1'b0),
        .bp_cnt_o     (s_bp_cnt)
    );

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (down_valid !== 1'b0) begin n_err++; $display("FAIL reset_down_valid got %b want 0", down_valid); end
        n_cmp++; if (up_ready !== 1'b1) begin n_err++; $display("FAIL reset_up_ready got %b want 1", up_ready); end
        n_cmp++; if (down_data !== '0) begin n_err++; $display("FAIL reset_down_data got %h want 0", down_data); end
        n_cmp++; if (bp_cnt !== 16'd0) begin n_err++; $display("FAIL reset_bp_cnt got %0d want 0", bp_cnt); end
        #5 arst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        down_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            up_valid = 1'b1;
            up_data  = c_DW'(k);
            #1;
            n_cmp++; if (up_ready !== 1'b1) begin n_err++; $display("FAIL stream_up_ready beat %0d got %b want 1", k, up_ready); end
            tick();
            n_cmp++;
            if (down_valid !== 1'b1 || down_data !== c_DW'(k)) begin
                n_err++;
                $display("FAIL stream_out beat %0d got v=%b d=%h want v=1 d=%0h", k, down_valid, down_data, k);
            end
        end
        up_valid = 1'b0;
        tick();
        n_cmp++; if (down_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got v=%b want 0", down_valid); end
    endtask

    task automatic test_backpressure();
        down_ready = 1'b0;
        up_valid   = 1'b1;
        up_data    = c_DW'(8'hA);
        tick();
        n_cmp++; if (down_data !== c_DW'(8'hA) || up_ready !== 1'b1 || bp_cnt !== 16'd0) begin
            n_err++; $display("FAIL bp_first got d=%h rdy=%b cnt=%0d want A/1/0", down_data, up_ready, bp_cnt); end
        up_data = c_DW'(8'hB);
        tick();
        n_cmp++; if (down_data !== c_DW'(8'hA) || up_ready !== 1'b0 || bp_cnt !== 16'd1) begin
            n_err++; $display("FAIL bp_skid got d=%h rdy=%b cnt=%0d want A/0/1", down_data, up_ready, bp_cnt); end
        up_data = c_DW'(8'hC);
        tick();
        tick();
        n_cmp++; if (down_data !== c_DW'(8'hA) || up_ready !== 1'b0 || bp_cnt !== 16'd3) begin
            n_err++; $display("FAIL bp_stall got d=%h rdy=%b cnt=%0d want A/0/3", down_data, up_ready, bp_cnt); end
        down_ready = 1'b1;
        tick();
        n_cmp++; if (down_data !== c_DW'(8'hB) || up_ready !== 1'b1 || bp_cnt !== 16'd3) begin
            n_err++; $display("FAIL bp_release got d=%h rdy=%b cnt=%0d want B/1/3", down_data, up_ready, bp_cnt); end
        tick();
        n_cmp++; if (down_valid !== 1'b1 || down_data !== c_DW'(8'hC)) begin
            n_err++; $display("FAIL bp_third got v=%b d=%h want 1/C", down_valid, down_data); end
        up_valid = 1'b0;
        tick();
        n_cmp++; if (down_valid !== 1'b0 || bp_cnt !== 16'd3) begin
            n_err++; $display("FAIL bp_empty got v=%b cnt=%0d want 0/3", down_valid, bp_cnt); end
    endtask

    task automatic test_flush();
        down_ready = 1'b0;
        up_valid   = 1'b1;
        up_data    = c_DW'(8'h11);
        tick();
        up_data = c_DW'(8'h22);
        tick();
        n_cmp++; if (up_ready !== 1'b0 || bp_cnt !== 16'd4) begin
            n_err++; $display("FAIL flush_full got rdy=%b cnt=%0d want 0/4", up_ready, bp_cnt); end
        flush   = 1'b1;
        up_data = c_DW'(8'hD);
        tick();
        flush    = 1'b0;
        up_valid = 1'b0;
        #1;
        n_cmp++; if (down_valid !== 1'b0 || down_data !== '0 || up_ready !== 1'b1 || bp_cnt !== 16'd4) begin
            n_err++; $display("FAIL flush_bubble got v=%b d=%h rdy=%b cnt=%0d want 0/0/1/4", down_valid, down_data, up_ready, bp_cnt); end
        down_ready = 1'b1;
        tick();
        n_cmp++; if (down_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop got v=%b want 0", down_valid); end
    endtask

    task automatic test_hold_flush();
        down_ready = 1'b0;
        up_valid   = 1'b1;
        up_data    = c_DW'(8'h5);
        tick();
        up_valid   = 1'b1;
        up_data    = c_DW'(8'h6);
        hold_ena   = 1'b1;
        flush      = 1'b1;
        down_ready = 1'b1;
        #1;
        n_cmp++; if (up_ready !== 1'b0 || down_valid !== 1'b0) begin
            n_err++; $display("FAIL hold_gate got rdy=%b v=%b want 0/0", up_ready, down_valid); end
        tick();
        tick();
        n_cmp++; if (down_data !== c_DW'(8'h5) || up_ready !== 1'b0 || down_valid !== 1'b0 || bp_cnt !== 16'd4) begin
            n_err++; $display("FAIL hold_keep got d=%h rdy=%b v=%b cnt=%0d want 5/0/0/4", down_data, up_ready, down_valid, bp_cnt); end
        hold_ena = 1'b0;
        flush    = 1'b0;
        up_valid = 1'b0;
        #1;
        n_cmp++; if (down_valid !== 1'b1 || down_data !== c_DW'(8'h5)) begin
            n_err++; $display("FAIL hold_release got v=%b d=%h want 1/5", down_valid, down_data); end
        tick();
        n_cmp++; if (down_valid !== 1'b0) begin n_err++; $display("FAIL hold_delivered got v=%b want 0", down_valid); end
    endtask

    task automatic test_reset_mid();
        down_ready = 1'b0;
        up_valid   = 1'b1;
        up_data    = c_DW'(8'h77);
        tick();
        up_valid = 1'b0;
        #2 arst_n = 1'b0;
        #1;
        n_cmp++; if (down_valid !== 1'b0 || down_data !== '0 || up_ready !== 1'b1 || bp_cnt !== 16'd0) begin
            n_err++; $display("FAIL reset_mid got v=%b d=%h rdy=%b cnt=%0d want 0/0/1/0", down_valid, down_data, up_ready, bp_cnt); end
        #3 arst_n = 1'b1;
        tick();
    endtask

    task automatic test_saturate();
        s_down_ready = 1'b0;
        s_up_valid   = 1'b1;
        s_up_data    = 8'h33;
        for (int i = 0; i < 15; i++) tick();
        n_cmp++; if (s_bp_cnt !== 4'd14) begin n_err++; $display("FAIL sat_before got %0d want 14", s_bp_cnt); end
        tick();
        n_cmp++; if (s_bp_cnt !== 4'd15) begin n_err++; $display("FAIL sat_reach got %0d want 15", s_bp_cnt); end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (s_bp_cnt !== 4'd15 || s_down_data !== 8'h33) begin
            n_err++; $display("FAIL sat_hold got cnt=%0d d=%h want 15/33", s_bp_cnt, s_down_data); end
        s_up_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_hold_flush();
        test_reset_mid();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register with a valid/ready handshake and a one-entry skid buffer. It is the successor to the fixed-format ID/EX register. It carries an opaque payload of DATA_W bits, supports back-pressure, and has a pipeline-controller hold and flush with bubble injection. It also has a saturating back-pressure counter. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM) and is instantiated once per boundary.

## Interface
Parameters:
- DATA_W, 294, payload width. The default is the ID/EX bundle: inst 32, inst_addr 32, reg1/reg2 data 64, reg_w_e 1, reg_w_addr 5, op1/op2/op1_jump/op2_jump 128, padded to 294.
- BUBBLE_VAL, {DATA_W{1'b0}}, payload value written on reset and flush.
- CNT_W, 16, back-pressure counter width.

Ports:
- clk_100MHz  in  1  clock.
- arst_n  in  1  asynchronous, active-low reset.
- up_valid_i  in  1  upstream payload valid.
- up_ready_o  out  1  stage can accept upstream payload.
- up_data_i  in  DATA_W  upstream payload.
- down_valid_o  out  1  output payload valid.
- down_ready_i  in  1  downstream accepts payload.
- down_data_o  out  DATA_W  output payload (registered).
- hold_ena_i  in  1  controller stall; freezes the stage.
- flush_i  in  1  controller flush (jump/redirect); kills stage contents.
- bp_cnt_o  out  CNT_W  saturating count of back-pressure cycles.

## Operation
- Definitions:
  - up_fire = up_valid_i & up_ready_o.
  - down_fire = down_valid_o & down_ready_i.
- Storage:
  - Output register out_q (drives down_data_o).
  - Skid register skid_q.
  - 2-bit state.
- States:
  - EMPTY: no valid data.
  - BUSY: out_q valid, skid_q empty.
  - FULL: both valid.
- Outputs:
  - up_ready_o = (state != FULL) & ~hold_ena_i. It depends only on state and hold, never combinationally on down_ready_i.
  - down_valid_o = (state != EMPTY) & ~hold_ena_i.
- Priority: reset > hold > flush > normal.
- Hold:
  - All registers (state, out_q, skid_q, bp_cnt) are unchanged.
  - No transfers occur on either side, because both handshake outputs are gated to 0.
- Flush (no hold):
  - state → EMPTY; out_q and skid_q ← BUBBLE_VAL.
  - An up_valid_i present in the same cycle is discarded.
  - down_valid_o may be 1 in the flush cycle. If down_fire also occurs, downstream has taken the old payload; that is legal, and the controller flushes downstream separately.
- Normal transitions:
  - EMPTY, up_fire → out_q ← up_data_i, BUSY.
  - BUSY, up_fire & down_fire → out_q ← up_data_i, stay BUSY.
  - BUSY, up_fire & ~down_fire → skid_q ← up_data_i, FULL.
  - BUSY, ~up_fire & down_fire → EMPTY; out_q keeps its stale value.
  - FULL, down_fire → out_q ← skid_q, BUSY. up_fire is impossible in FULL.
  - All other combinations → no change.
- Ordering: payloads leave in acceptance order. There is no loss and no duplication.
- Back-pressure counter:
  - bp_cnt increments when down_valid_o & ~down_ready_i and not flushing.
  - It saturates at all ones.
  - It is cleared only by reset; flush does not clear it.

## Timing
- Reset (asynchronous assert, synchronous deassert upstream of this block):
  - state = EMPTY, out_q = skid_q = BUBBLE_VAL, bp_cnt_o = 0.
  - down_valid_o = 0; up_ready_o = 1 (if hold is low).
- Latency: up_fire in cycle N → down_valid_o = 1 with that payload in cycle N+1.
- Throughput: 1 payload/cycle sustained while down_ready_i = 1.
- Back-pressure:
  - One extra beat is absorbed into the skid register.
  - up_ready_o drops the cycle after the skid fills.
  - It recovers the cycle after the first down_fire in FULL.
- Hold or flush asserted for k cycles: effects are per cycle, with no internal pending state.
- Reset mid-transfer: all contents are lost and outputs return to reset values immediately.

## Structure
- Shared package pipe_pkg holds:
  - State encoding: EMPTY=2'b00, BUSY=2'b01, FULL=2'b10.
  - ID/EX payload field widths and bit offsets, used by the pack/unpack at instantiation sites.
- Sub-module pipe_sat_counter (parameter W; ports inc, count) implements bp_cnt.
- Everything else is in one always block plus continuous assigns.

## Test plan
- Reset → down_valid_o=0, up_ready_o=1, down_data_o=0, bp_cnt_o=0.
- Stream 0x1..0x8 with down_ready_i=1 → outputs 0x1..0x8 on consecutive cycles, each 1 cycle after acceptance.
- Send 0xA, 0xB, 0xC with down_ready_i=0 → 0xA in out, 0xB in skid, up_ready_o=0, 0xC not accepted; bp_cnt_o increments each cycle. Then release → 0xA, 0xB, 0xC delivered in order, bp_cnt_o stops.
- FULL state with flush_i=1 for 1 cycle plus up_valid_i (0xD) → next cycle down_valid_o=0, down_data_o=BUBBLE_VAL, 0xD dropped, up_ready_o=1.
- hold_ena_i=1 and flush_i=1 together while BUSY with 0x5 → both handshake outputs 0, out_q still 0x5; after hold drops, 0x5 is delivered.
- CNT_W=4 with down_ready_i=0 for 20 cycles → bp_cnt_o saturates at 15.
